rr_lock_arbiter: RTL
====================

RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
- REQ-001: Parameter AGENTS, default 8; number of requesters, legal range 2..32.
- REQ-002: Parameter MAX_HOLD, default 4; maximum consecutive grant cycles before preemption, legal range 1..255; used only when the timeout feature is compiled in.
- REQ-003: clock  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: r  input  AGENTS  request vector; bit i high means agent i requests or holds the resource.
- REQ-006: g  output  AGENTS  registered grant vector; one-hot or all-zero.
- REQ-007: grant_id  output  $clog2(AGENTS)  index of the granted agent; 0 when g is zero.
- REQ-008: busy  output  1  high exactly when g is non-zero.

Function
- REQ-009: Two-state FSM: IDLE (g=0) and OWNED (exactly one g bit high).
- REQ-010: Round-robin pointer ptr (width $clog2(AGENTS)) names the highest-priority agent.
- REQ-011: Arbitration picks the first set r bit searching ptr, ptr+1, ..., AGENTS-1, 0, ..., ptr-1 (wrap-around).
- REQ-012: IDLE with r != 0 at a rising edge: the winner's g bit is high after that edge (one-cycle latency); FSM goes to OWNED; ptr <= (winner+1) mod AGENTS.
- REQ-013: IDLE with r == 0: g stays 0; ptr unchanged.
- REQ-014: OWNED with r[owner] high: grant held unchanged (lock semantics), unless preempted under REQ-022.
- REQ-015: OWNED with r[owner] low at an edge: re-arbitrate over the current r on that same edge with no bubble cycle; if r == 0, g <= 0 and the FSM goes to IDLE.
- REQ-016: ptr updates only on a new grant; holding a grant never moves ptr.
- REQ-017: Wrap: a grant to agent AGENTS-1 sets ptr to 0.
- REQ-018: Requests by non-owners never alter g while the owner holds.
- REQ-019: g is never more than one-hot, in any cycle.
- REQ-020: grant_id and busy are consistent with g in every cycle.

Reset
- REQ-021: While reset is low, asynchronously and regardless of clock: g=0, grant_id=0, busy=0, ptr=0, FSM=IDLE, hold counter=0. This applies mid-grant. The first rising edge after reset goes high arbitrates as from IDLE with ptr=0.

Configuration
- REQ-022: Macro RR_ARB_TIMEOUT_EN defined: an 8-bit hold counter clears on each new grant and increments on each OWNED cycle. When the owner has held for MAX_HOLD cycles, r[owner] is still high, and another r bit is set, the next edge re-arbitrates excluding the owner. If no other request exists, the owner keeps the grant and the counter clears.
- REQ-023: Macro RR_ARB_TIMEOUT_EN undefined: no counter exists, MAX_HOLD is ignored, and a grant is held until r[owner] drops.

Verification (AGENTS=8, MAX_HOLD=4)
- REQ-024: Hold reset low with r=8'b1001_0111 -> g=0 and busy=0 on every edge. Then release reset -> first edge g=8'b0000_0001, grant_id=0.
- REQ-025: r=8'b1000_0010 -> g=8'b0000_0010. Drop bit1 (r=8'b1000_0000) -> next edge g=8'b1000_0000. Drop bit7 and raise bit1 (r=8'b0000_0010) -> next edge g=8'b0000_0010 (wrap).
- REQ-026: Owner 1 holds with r=8'b1111_1111 for 10 cycles, timeout macro undefined -> g stays 8'b0000_0010. Drop bit1 -> next edge g=8'b0000_0100.
- REQ-027: Timeout macro defined, r=8'b0000_0011 held constant -> g alternates 8'b0000_0001 and 8'b0000_0010 every 4 cycles. With r=8'b0000_0001 only -> g=8'b0000_0001 indefinitely.
- REQ-028: Pull reset low between edges while g=8'b0000_0100 -> g=0 and busy=0 immediately, with no clock edge. After release with r=8'b0000_0100 -> g=8'b0000_0100 and ptr=3.
- REQ-029: Random r for 10k cycles -> $onehot0(g) holds every cycle. Every continuously requesting agent is granted within AGENTS grants (timeout build).

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter -- round-robin arbiter with lock (hold) semantics.
//
// A requester that wins keeps the grant for as long as it keeps its request
// bit high. When the owner releases, the next owner is picked on the same
// edge (no bubble), searching from the round-robin pointer with wrap-around.
// The pointer moves only when a new grant is issued.
//
// Optional feature (compile-time macro RR_ARB_TIMEOUT_EN):
//   An 8-bit hold counter limits an owner to MAX_HOLD consecutive cycles
//   when someone else is waiting. Preemption re-arbitrates with the owner
//   masked out. With no other requester the owner keeps the grant and the
//   counter restarts. Without the macro MAX_HOLD has no effect.
//
// Parameters:
//   AGENTS    number of requesters (2..32)
//   MAX_HOLD  hold limit in cycles (1..255), timeout build only
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   r         request vector, one bit per agent
//   g         registered grant vector, one-hot or zero
//   grant_id  index of the granted agent, 0 when idle
//   busy      high exactly when g is non-zero

// Per-agent qualification: a request is eligible unless this agent is the
// current owner and is being preempted.
module rr_lock_arbiter_lane (
  input  logic req,
  input  logic own,
  input  logic excl,
  output logic elig
);
  assign elig = req & ~(own & excl);
endmodule

module rr_lock_arbiter #(
  parameter int AGENTS   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [AGENTS-1:0]         r,
  output logic [AGENTS-1:0]         g,
  output logic [$clog2(AGENTS)-1:0] grant_id,
  output logic                      busy
);
  localparam int IW = $clog2(AGENTS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0]        state;
  logic [IW-1:0]     ptr;
  logic              owner_req;
  logic              others;
  logic              excl;
  logic              do_arb;
  logic              found;
  logic [IW-1:0]     winner;
  logic [AGENTS-1:0] elig;

  assign owner_req = r[grant_id];
  assign others    = |(r & ~g);
  assign busy      = |g;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       expire;

  // hold_cnt is 0 during the first owned cycle, so the limit is reached
  // when it shows MAX_HOLD-1 at an edge.
  assign expire = (hold_cnt >= 8'(MAX_HOLD - 1));
  assign excl   = (state == OWNED) & owner_req & expire & others;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^8'(MAX_HOLD);
  assign excl            = 1'b0;
`endif

  for (genvar i = 0; i < AGENTS; i++) begin : g_lane
    rr_lock_arbiter_lane u_lane (
      .req  (r[i]),
      .own  (g[i]),
      .excl (excl),
      .elig (elig[i])
    );
  end

  // Arbitrate when idle, when the owner has released, or on preemption.
  assign do_arb = (state == IDLE) | ~owner_req | excl;

  // First eligible agent at or after ptr, wrapping at AGENTS.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < AGENTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= AGENTS) idx = idx - AGENTS;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      g        <= '0;
      grant_id <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else if (do_arb && found) begin
      state    <= OWNED;
      g        <= AGENTS'(1) << winner;
      grant_id <= winner;
      ptr      <= (winner == IW'(AGENTS - 1)) ? '0 : winner + 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else if (state == OWNED && !owner_req) begin
      // owner released and nobody else is asking
      state    <= IDLE;
      g        <= '0;
      grant_id <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end
`ifdef RR_ARB_TIMEOUT_EN
    else if (state == OWNED) begin
      // limit reached with nobody waiting: owner keeps it, window restarts
      hold_cnt <= expire ? 8'd0 : hold_cnt + 8'd1;
    end
`endif
  end

endmodule
